vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_plot_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Three-requester rectangle-fill arbiter for a VGA adapter plot port.
// Requesters are granted round-robin. Each granted job is drawn one pixel per cycle, with off-screen pixels clipped.
module vga_plot_arbiter #(
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [23:0] job_x,
  input  logic [20:0] job_y,
  input  logic [23:0] job_w,
  input  logic [20:0] job_h,
  input  logic [17:0] job_colour,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [5:0]  colour,
  output logic        writeEn
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state_reg;
  logic [1:0] last_reg;
  logic [7:0] x0_reg, w_reg, cx_reg;
  logic [6:0] y0_reg, h_reg, cy_reg;

  logic [7:0] req_x [3];
  logic [6:0] req_y [3];
  logic [7:0] req_w [3];
  logic [6:0] req_h [3];
  logic [5:0] req_c [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign req_x[gi] = job_x[8*gi +: 8];
      assign req_y[gi] = job_y[7*gi +: 7];
      assign req_w[gi] = job_w[8*gi +: 8];
      assign req_h[gi] = job_h[7*gi +: 7];
      assign req_c[gi] = job_colour[6*gi +: 6];
    end
  endgenerate

  // Round-robin search starts one past the last granted index.
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [2:0] cand;
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = {1'b0, last_reg} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!gnt_valid && req[cand[1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[1:0];
      end
    end
  end

  logic [7:0] sel_x, sel_w;
  logic [6:0] sel_y, sel_h;
  logic [5:0] sel_c;
  logic       sel_zero, sel_on_screen;
  assign sel_x         = req_x[gnt_idx];
  assign sel_y         = req_y[gnt_idx];
  assign sel_w         = req_w[gnt_idx];
  assign sel_h         = req_h[gnt_idx];
  assign sel_c         = req_c[gnt_idx];
  assign sel_zero      = (sel_w == 8'd0) || (sel_h == 7'd0);
  assign sel_on_screen = ({1'b0, sel_x} < 9'(X_MAX)) && ({1'b0, sel_y} < 8'(Y_MAX));

  // cx/cy track the pixel currently on the outputs; next_* is the one registered next.
  logic       zero_area, col_wrap, last_pix;
  logic [7:0] next_cx;
  logic [6:0] next_cy;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  always_comb begin
    zero_area = (w_reg == 8'd0) || (h_reg == 7'd0);
    col_wrap  = (cx_reg == w_reg - 8'd1);
    // A zero-area job idles for one extra DRAW cycle after the ack cycle.
    last_pix  = zero_area ? (cx_reg == 8'd1) : (col_wrap && (cy_reg == h_reg - 7'd1));
    next_cx   = col_wrap ? 8'd0 : cx_reg + 8'd1;
    next_cy   = col_wrap ? cy_reg + 7'd1 : cy_reg;
    sum_x     = {1'b0, x0_reg} + {1'b0, next_cx};
    sum_y     = {1'b0, y0_reg} + {1'b0, next_cy};
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      last_reg  <= 2'd2;
      ack       <= 3'd0;
      done      <= 3'd0;
      writeEn   <= 1'b0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 6'd0;
      cx_reg    <= 8'd0;
      cy_reg    <= 7'd0;
      x0_reg    <= 8'd0;
      y0_reg    <= 7'd0;
      w_reg     <= 8'd0;
      h_reg     <= 7'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done    <= 3'd0;
          writeEn <= 1'b0;
          if (gnt_valid) begin
            state_reg <= DRAW;
            last_reg  <= gnt_idx;
            ack       <= 3'b001 << gnt_idx;
            x0_reg    <= sel_x;
            y0_reg    <= sel_y;
            w_reg     <= sel_w;
            h_reg     <= sel_h;
            cx_reg    <= 8'd0;
            cy_reg    <= 7'd0;
            if (!sel_zero) begin
              x       <= sel_x;
              y       <= sel_y;
              colour  <= sel_c;
              writeEn <= sel_on_screen;
            end
          end
        end
        DRAW: begin
          ack <= 3'd0;
          if (last_pix) begin
            state_reg <= DONE;
            writeEn   <= 1'b0;
            done      <= 3'b001 << last_reg;
            cx_reg    <= 8'd0;
            cy_reg    <= 7'd0;
          end else if (zero_area) begin
            cx_reg <= 8'd1;
          end else begin
            cx_reg  <= next_cx;
            cy_reg  <= next_cy;
            x       <= sum_x[7:0];
            y       <= sum_y[6:0];
            writeEn <= (sum_x < 9'(X_MAX)) && (sum_y < 8'(Y_MAX));
          end
        end
        DONE: begin
          done      <= 3'd0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized and directed bench for vga_plot_arbiter.
// A job-level model predicts the grant order and the per-cycle pixel trace.
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [23:0] job_x, job_w;
  logic [20:0] job_y, job_h;
  logic [17:0] job_colour;
  logic [2:0]  ack, done;
  logic        busy, writeEn;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [5:0]  colour;

  logic [7:0] fx [3];
  logic [7:0] fw [3];
  logic [6:0] fy [3];
  logic [6:0] fh [3];
  logic [5:0] fc [3];

  assign job_x      = {fx[2], fx[1], fx[0]};
  assign job_y      = {fy[2], fy[1], fy[0]};
  assign job_w      = {fw[2], fw[1], fw[0]};
  assign job_h      = {fh[2], fh[1], fh[0]};
  assign job_colour = {fc[2], fc[1], fc[0]};

  vga_plot_arbiter #(.X_MAX(160), .Y_MAX(120)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .job_x(job_x), .job_y(job_y), .job_w(job_w), .job_h(job_h), .job_colour(job_colour),
    .ack(ack), .done(done), .busy(busy),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int model_last = 2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int predict_grant(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic set_job(input int i, input int jx, input int jy, input int jw, input int jh, input int jc);
    fx[i] = 8'(jx); fy[i] = 7'(jy); fw[i] = 8'(jw); fh[i] = 7'(jh); fc[i] = 6'(jc);
  endtask

  task automatic rand_job(input int i);
    set_job(i, $urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 5),
            $urandom_range(0, 4), $urandom_range(0, 63));
  endtask

  // Called in an IDLE cycle with req already set; runs one full job.
  // drop: 0 keep req, 1 clear req, 2 clear at random.
  task automatic do_job(input int drop);
    int g, jx, jy, jw, jh, jc, n, cx, cy, ex, ey;
    bit zero, we;
    g = predict_grant(req, model_last);
    if (g < 0) begin
      check_eq("req_nonzero", 32'(req), 32'd7);
      return;
    end
    model_last = g;
    jx = fx[g]; jy = fy[g]; jw = fw[g]; jh = fh[g]; jc = fc[g];
    zero = (jw == 0) || (jh == 0);
    n = zero ? 2 : jw * jh;
    $display("job grant=%0d x0=%0d y0=%0d w=%0d h=%0d colour=%0h", g, jx, jy, jw, jh, jc);
    tick();
    check_eq("ack", 32'(ack), 32'(1 << g));
    check_eq("busy_draw", 32'(busy), 32'd1);
    for (int p = 0; p < n; p++) begin
      cx = zero ? 0 : p % jw;
      cy = zero ? 0 : p / jw;
      ex = jx + cx;
      ey = jy + cy;
      we = !zero && (ex < 160) && (ey < 120);
      check_eq("writeEn", 32'(writeEn), 32'(we));
      if (we) begin
        check_eq("x", 32'(x), 32'(ex));
        check_eq("y", 32'(y), 32'(ey));
        check_eq("colour", 32'(colour), 32'(jc));
      end
      if (p > 0) check_eq("ack_clear", 32'(ack), 32'd0);
      check_eq("done_early", 32'(done), 32'd0);
      tick();
    end
    check_eq("done", 32'(done), 32'(1 << g));
    check_eq("writeEn_done", 32'(writeEn), 32'd0);
    check_eq("busy_done", 32'(busy), 32'd1);
    if (drop == 1 || (drop == 2 && $urandom_range(0, 1) == 1)) req[g] = 1'b0;
    rand_job(g);
    tick();
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("done_clear", 32'(done), 32'd0);
    check_eq("writeEn_idle", 32'(writeEn), 32'd0);
    check_eq("ack_idle", 32'(ack), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"}, 32'(ack), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_we"}, 32'(writeEn), 32'd0);
    check_eq({tag, "_xyc"}, {17'd0, x, y, colour}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req = 3'b000;
    for (int i = 0; i < 3; i++) set_job(i, 0, 0, 1, 1, 0);
    tick(); tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    check_all_zero("idle");

    // Single job on requester 1.
    set_job(1, 10, 20, 3, 2, 'h30);
    req = 3'b010;
    do_job(1);

    // Clipping at the bottom-right corner.
    set_job(0, 158, 119, 4, 2, 'h15);
    req = 3'b001;
    do_job(1);

    // Zero-area job.
    set_job(2, 5, 5, 0, 5, 'h3f);
    req = 3'b100;
    do_job(1);

    // Reset in the 4th DRAW cycle of a 10x10 job.
    set_job(0, 30, 30, 10, 10, 'h2a);
    req = 3'b001;
    tick();
    check_eq("rst_ack", 32'(ack), 32'd1);
    tick(); tick(); tick();
    check_eq("rst_we_before", 32'(writeEn), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    req = 3'b000;
    tick(); tick();
    check_eq("rst_no_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    model_last = 2;
    set_job(2, 40, 50, 2, 2, 'h11);
    req = 3'b100;
    do_job(1);

    // Contention: all three requesting 1x1 jobs.
    for (int i = 0; i < 3; i++) set_job(i, 20 + i, 20 + i, 1, 1, i + 1);
    req = 3'b111;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 3; i++) if (!req[i]) set_job(i, 20 + i, 20 + i, 1, 1, i + 1);
      req = 3'b111;
      do_job(0);
    end
    req = 3'b000;

    // Randomized traffic.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          rand_job(i);
          req[i] = 1'b1;
        end
      end
      if (req == 3'b000) begin
        rand_job(j % 3);
        req[j % 3] = 1'b1;
      end
      do_job(2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
